// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: prefix bytes, frame FSM encoding, game scan codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

  // Prefix bytes folded into flags rather than reported as codes
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // Frame receive state
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // Scan codes consumed by the downstream direction decoder
  localparam logic [7:0] SC_BLUE_0 = 8'hAC;
  localparam logic [7:0] SC_BLUE_1 = 8'h5D;
  localparam logic [7:0] SC_BLUE_2 = 8'h5C;
  localparam logic [7:0] SC_BLUE_3 = 8'h9D;
  localparam logic [7:0] SC_RED_0  = 8'h70;
  localparam logic [7:0] SC_RED_1  = 8'h71;
  localparam logic [7:0] SC_RED_2  = 8'hB1;
  localparam logic [7:0] SC_RED_3  = 8'h88;
  localparam logic [7:0] SC_STOP   = 8'h1F;

  // True when data bits plus the parity bit hold an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Scan-code event bus from the PS/2 receiver to the direction decoder.
// Latency: n/a (wires only).
// Backpressure: none; events are single-cycle pulses the consumer must take.
interface ps2_scancode_rx_if;
  logic [7:0] code;
  logic       code_ext;
  logic       code_brk;
  logic       code_valid;
  logic       frame_err;

  modport master (output code, code_ext, code_brk, code_valid, frame_err);
  modport slave  (input  code, code_ext, code_brk, code_valid, frame_err);
endinterface

// File: rtl/ps2_line_filter.sv
// Resynchronises one raw PS/2 pin and only follows it after FILTER_LEN identical samples.
// Latency: 2 sync cycles plus FILTER_LEN samples before line_out changes.
// Backpressure: none; free-running conditioning of an asynchronous pin.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic line_out
);

  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] diff_cnt;

  // Two-flop synchroniser; idle PS/2 lines are high, so reset to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= line_in;
      sync_2 <= sync_1;
    end
  end

  // Count consecutive samples disagreeing with the output; flip on the FILTER_LEN-th
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_out <= 1'b1;
      diff_cnt <= '0;
    end else if (sync_2 == line_out) begin
      diff_cnt <= '0;
    end else if (diff_cnt == CW'(FILTER_LEN - 1)) begin
      line_out <= sync_2;
      diff_cnt <= '0;
    end else begin
      diff_cnt <= diff_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: frames 11-bit packets, checks parity/stop, folds E0/F0 into flags.
// Latency: code_valid/frame_err one clk after the fall_evt that samples the stop bit.
// Backpressure: none; one-cycle event pulses, code fields hold until the next code_valid.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TMO_W          = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ps2_clk,
  input  logic                  ps2_dat,
  ps2_scancode_rx_if.master     evt
);

  logic             clk_f;
  logic             dat_f;
  logic             clk_f_q;
  logic             fall_evt;

  ps2_state_t       state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             par_acc;
  logic             par_ok;
  logic [TMO_W-1:0] tmo_cnt;
  logic             ext_flag;
  logic             brk_flag;

  logic [7:0]       code_q;
  logic             code_ext_q;
  logic             code_brk_q;
  logic             code_valid_q;
  logic             frame_err_q;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_in  (ps2_clk),
    .line_out (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_in  (ps2_dat),
    .line_out (dat_f)
  );

  // Delayed filtered clock for 1->0 edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clk_f_q <= 1'b1;
    else        clk_f_q <= clk_f;
  end

  assign fall_evt = clk_f_q & ~clk_f;

  // Frame FSM with timeout, prefix tracking and registered event outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_acc      <= 1'b0;
      par_ok       <= 1'b0;
      tmo_cnt      <= '0;
      ext_flag     <= 1'b0;
      brk_flag     <= 1'b0;
      code_q       <= '0;
      code_ext_q   <= 1'b0;
      code_brk_q   <= 1'b0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (state == IDLE) begin
        tmo_cnt <= '0;
        // A high level here is line noise or a late bit; ignore it
        if (fall_evt && !dat_f) begin
          state   <= DATA;
          bit_cnt <= '0;
          par_acc <= 1'b0;
        end
      end else if (fall_evt) begin
        tmo_cnt <= '0;
        case (state)
          DATA: begin
            shreg   <= {dat_f, shreg[7:1]};
            par_acc <= par_acc ^ dat_f;
            if (bit_cnt == 3'd7) state <= PARITY;
            else                 bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: begin
            par_ok <= par_acc ^ dat_f;
            state  <= STOP;
          end
          default: begin
            state <= IDLE;
            if (dat_f && par_ok) begin
              if (shreg == PS2_PREFIX_EXT) begin
                ext_flag <= 1'b1;
              end else if (shreg == PS2_PREFIX_BRK) begin
                brk_flag <= 1'b1;
              end else begin
                code_q       <= shreg;
                code_ext_q   <= ext_flag;
                code_brk_q   <= brk_flag;
                code_valid_q <= 1'b1;
                ext_flag     <= 1'b0;
                brk_flag     <= 1'b0;
              end
            end else begin
              // A corrupted byte may have been a prefix; drop any half-built sequence
              frame_err_q <= 1'b1;
              ext_flag    <= 1'b0;
              brk_flag    <= 1'b0;
            end
          end
        endcase
      end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        // Keyboard stopped clocking mid-frame: abort and resynchronise on the next start bit
        state       <= IDLE;
        tmo_cnt     <= '0;
        frame_err_q <= 1'b1;
        ext_flag    <= 1'b0;
        brk_flag    <= 1'b0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  assign evt.code       = code_q;
  assign evt.code_ext   = code_ext_q;
  assign evt.code_brk   = code_brk_q;
  assign evt.code_valid = code_valid_q;
  assign evt.frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx with a scoreboard of expected events.
// Latency: checks events arrive 7 clks after the driven stop-bit falling edge.
// Backpressure: n/a.
module tb_ps2_scancode_rx;
  import ps2_pkg::*;

  localparam int TMO  = 300;
  localparam int HALF = 20;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;

  ps2_scancode_rx_if bus ();

  ps2_scancode_rx #(
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (TMO),
    .TMO_W          (9)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .evt     (bus)
  );

  always #10 clk = ~clk;

  int n_vec     = 0;
  int n_err     = 0;
  int cyc       = 0;
  int last_fall = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    bit         ext;
    bit         brk;
    bit         chk_lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_code(input logic [7:0] c, input bit e, input bit b);
    exp_t x;
    x.is_err = 1'b0; x.code = c; x.ext = e; x.brk = b; x.chk_lat = 1'b1;
    sb.push_back(x);
  endtask

  task automatic exp_err(input bit lat);
    exp_t x;
    x.is_err = 1'b1; x.code = 8'h00; x.ext = 1'b0; x.brk = 1'b0; x.chk_lat = lat;
    sb.push_back(x);
  endtask

  // Scoreboard monitor: every event pulse must match the head of the queue
  always @(negedge clk) begin
    if (rst_n && (bus.code_valid || bus.frame_err)) begin
      chk("valid_err_exclusive", {31'd0, bus.code_valid & bus.frame_err}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_event", {30'd0, bus.code_valid, bus.frame_err}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("event_is_err", {31'd0, bus.frame_err}, {31'd0, mon_e.is_err});
        if (!mon_e.is_err) begin
          chk("code", {24'd0, bus.code}, {24'd0, mon_e.code});
          chk("code_ext", {31'd0, bus.code_ext}, {31'd0, mon_e.ext});
          chk("code_brk", {31'd0, bus.code_brk}, {31'd0, mon_e.brk});
        end
        if (mon_e.chk_lat) chk("latency", cyc - last_fall, 32'd7);
      end
    end
  end

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_dat = b;
    if (glitch) begin
      repeat (5) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (2) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF - 7) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk   = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit glitch);
    logic p;
    p = (~^b) ^ bad_par;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
    ps2_bit(p, glitch);
    ps2_bit(~bad_stop, 1'b0);
    ps2_dat = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i], 1'b0);
    ps2_dat = 1'b1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_code"}, {24'd0, bus.code}, 32'd0);
    chk({tag, "_flags"}, {29'd0, bus.code_ext, bus.code_brk, bus.code_valid}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, bus.frame_err}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    chk("reset_state", {30'd0, dut.state}, {30'd0, IDLE});
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Plain make code
    exp_code(8'h1D, 1'b0, 1'b0);
    send_frame(8'h1D, 1'b0, 1'b0, 1'b0);
    chk("drain_1d", sb.size(), 32'd0);

    // Break prefix: no event, code held
    send_frame(PS2_PREFIX_BRK, 1'b0, 1'b0, 1'b0);
    chk("drain_f0", sb.size(), 32'd0);
    chk("hold_after_f0", {24'd0, bus.code}, 32'h1D);
    exp_code(8'h1D, 1'b0, 1'b1);
    send_frame(8'h1D, 1'b0, 1'b0, 1'b0);
    exp_code(8'h1D, 1'b0, 1'b0);
    send_frame(8'h1D, 1'b0, 1'b0, 1'b0);
    chk("drain_brk", sb.size(), 32'd0);

    // Both prefixes in either order
    exp_code(8'h75, 1'b1, 1'b1);
    send_frame(PS2_PREFIX_EXT, 1'b0, 1'b0, 1'b0);
    send_frame(PS2_PREFIX_BRK, 1'b0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0, 1'b0);
    exp_code(SC_STOP, 1'b1, 1'b1);
    send_frame(PS2_PREFIX_BRK, 1'b0, 1'b0, 1'b0);
    send_frame(PS2_PREFIX_EXT, 1'b0, 1'b0, 1'b0);
    send_frame(SC_STOP, 1'b0, 1'b0, 1'b0);
    chk("drain_ext_brk", sb.size(), 32'd0);

    // Parity error clears a pending break prefix
    send_frame(PS2_PREFIX_BRK, 1'b0, 1'b0, 1'b0);
    exp_err(1'b1);
    send_frame(8'h1D, 1'b1, 1'b0, 1'b0);
    exp_code(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    chk("drain_parity", sb.size(), 32'd0);

    // Stop-bit error; code fields keep last value
    exp_err(1'b1);
    send_frame(8'h2A, 1'b0, 1'b1, 1'b0);
    chk("drain_stop", sb.size(), 32'd0);
    chk("hold_after_err", {24'd0, bus.code}, 32'h1C);

    // Timeout mid-frame, with a pending ext prefix that must be dropped
    send_frame(PS2_PREFIX_EXT, 1'b0, 1'b0, 1'b0);
    exp_err(1'b0);
    send_partial(8'h5A, 4);
    repeat (TMO + 10) @(negedge clk);
    chk("drain_timeout", sb.size(), 32'd0);
    chk("timeout_idle", {30'd0, dut.state}, {30'd0, IDLE});
    exp_code(8'h23, 1'b0, 1'b0);
    send_frame(8'h23, 1'b0, 1'b0, 1'b0);
    chk("drain_after_tmo", sb.size(), 32'd0);

    // Short low glitches on the PS/2 clock must not shift bits
    exp_code(SC_RED_0, 1'b0, 1'b0);
    send_frame(SC_RED_0, 1'b0, 1'b0, 1'b1);
    chk("drain_glitch", sb.size(), 32'd0);

    // Reset mid-frame with a pending prefix
    send_frame(PS2_PREFIX_BRK, 1'b0, 1'b0, 1'b0);
    send_partial(8'hFF, 4);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("midreset");
    rst_n = 1'b1;
    repeat (HALF) @(negedge clk);
    exp_code(SC_BLUE_1, 1'b0, 1'b0);
    send_frame(SC_BLUE_1, 1'b0, 1'b0, 1'b0);
    chk("drain_final", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
